// File: rtl/fpu_pkg.sv
// Shared FPU definitions: format widths, biases and exponent-class helpers.
// Imported by the adder and multiplier exponent paths.
package fpu_pkg;

    localparam int EXP_W_SP    = 8;
    localparam int EXP_W_DP    = 11;
    localparam int EXP_BIAS_SP = 127;
    localparam int EXP_BIAS_DP = 1023;

    typedef enum logic [1:0] {
        EXP_NORMAL = 2'd0,
        EXP_MAX    = 2'd1,
        EXP_MIN    = 2'd2
    } exp_class_t;

    function automatic logic [31:0] exp_all_ones(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/exp_classify.sv
// Combinational exponent classifier: saturates, denormalises or passes ie.
// Shared by the adder and multiplier exponent paths.
module exp_classify
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic [EXP_W+1:0] ie,
    input  logic             ftz,
    output logic [EXP_W-1:0] exp_out,
    output logic             max_exp,
    output logic             min_exp,
    output logic [EXP_W+1:0] excess_shift,
    output logic             flush_zero,
    output exp_class_t       cls
);

    localparam logic [EXP_W+1:0] IE_MAX = (EXP_W+2)'(exp_all_ones(EXP_W));

    logic ie_neg;
    logic is_ovf;
    logic is_unf;

    assign ie_neg = ie[EXP_W+1];
    assign is_ovf = !ie_neg && (ie >= IE_MAX);
    assign is_unf = ie_neg || (ie == '0);

    // Classify the signed exponent; ovf and unf ranges never overlap
    always_comb begin
        exp_out      = '0;
        max_exp      = 1'b0;
        min_exp      = 1'b0;
        excess_shift = '0;
        flush_zero   = 1'b0;
        cls          = EXP_NORMAL;
        unique case (1'b1)
            is_ovf: begin
                exp_out = '1;
                max_exp = 1'b1;
                cls     = EXP_MAX;
            end
            is_unf: begin
                min_exp = 1'b1;
                cls     = EXP_MIN;
                if (ftz)
                    flush_zero = 1'b1;
                else
                    excess_shift = -ie;
            end
            default: begin
                exp_out = ie[EXP_W-1:0];
            end
        endcase
    end

endmodule

// File: rtl/exp_update_pipe.sv
// Two-stage valid/ready exponent update for the FP adder.
// Stage 1 forms the signed exponent, stage 2 holds the classified result.
module exp_update_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int SUM_W   = 27,
    parameter int SHIFT_W = 5,
    parameter int EXC_W   = EXP_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   exp_in,
    input  logic               ovf,
    input  logic               ovf_rnd,
    input  logic [SHIFT_W-1:0] lz_shift,
    input  logic               one_shift_left,
    input  logic [1:0]         sum_top,
    input  logic               ftz_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   exp_out,
    output logic               max_exp,
    output logic               min_exp,
    output logic [EXC_W-1:0]   excess_shift,
    output logic               flush_zero,
    output logic               sticky_ovf,
    output logic               sticky_unf,
    input  logic               flag_clr
);

    localparam int IE_W = EXP_W + 2;

    if (SUM_W < 2 || SHIFT_W > EXP_W + 1) begin : g_bad_cfg
        $error("exp_update_pipe: unsupported SUM_W/SHIFT_W");
    end

    logic            path_left;
    logic [IE_W-1:0] shift;
    logic [IE_W-1:0] ie_next;
    logic            s2_advance;
    logic            out_hs;

    logic            s1_valid;
    logic [IE_W-1:0] s1_ie;
    logic            s1_ftz;

    logic [EXP_W-1:0] c_exp;
    logic             c_max;
    logic             c_min;
    logic [IE_W-1:0]  c_excess;
    logic             c_flush;
    exp_class_t       c_cls;
    exp_class_t       s2_cls;

    assign path_left  = ({ovf, sum_top} == 3'b000);
    assign shift      = path_left ? IE_W'(lz_shift) : IE_W'(one_shift_left);
    assign ie_next    = IE_W'(exp_in) + IE_W'(ovf) + IE_W'(ovf_rnd) - shift;
    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;
    assign out_hs     = out_valid && out_ready;

    // Stage 1: capture the unclassified exponent and FTZ mode
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ie    <= '0;
            s1_ftz   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ie  <= ie_next;
                s1_ftz <= ftz_mode;
            end
        end
    end

    exp_classify #(
        .EXP_W(EXP_W)
    ) u_classify (
        .ie          (s1_ie),
        .ftz         (s1_ftz),
        .exp_out     (c_exp),
        .max_exp     (c_max),
        .min_exp     (c_min),
        .excess_shift(c_excess),
        .flush_zero  (c_flush),
        .cls         (c_cls)
    );

    // Stage 2: hold the classified result until downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            exp_out      <= '0;
            max_exp      <= 1'b0;
            min_exp      <= 1'b0;
            excess_shift <= '0;
            flush_zero   <= 1'b0;
            s2_cls       <= EXP_NORMAL;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                exp_out      <= c_exp;
                max_exp      <= c_max;
                min_exp      <= c_min;
                excess_shift <= EXC_W'(c_excess);
                flush_zero   <= c_flush;
                s2_cls       <= c_cls;
            end
        end
    end

    // Sticky status: a result delivered this cycle beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            sticky_ovf <= (sticky_ovf && !flag_clr) ||
                          (out_hs && s2_cls == EXP_MAX);
            sticky_unf <= (sticky_unf && !flag_clr) ||
                          (out_hs && s2_cls == EXP_MIN);
        end
    end

endmodule

// File: tb/tb_exp_update_pipe.sv
// Self-checking bench for exp_update_pipe (EXP_W=8 and EXP_W=11).
// Table vectors, corner sequences and a randomized scoreboard run.
module tb_exp_update_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, ovf, ovf_rnd, one_shift_left, ftz_mode;
    logic [7:0] exp_in, exp_out;
    logic [4:0] lz_shift;
    logic [1:0] sum_top;
    logic       out_valid, out_ready, max_exp, min_exp, flush_zero;
    logic [9:0] excess_shift;
    logic       sticky_ovf, sticky_unf, flag_clr;

    logic        d_in_valid, d_in_ready, d_ovf, d_ovf_rnd, d_osl, d_ftz;
    logic [10:0] d_exp_in, d_exp_out;
    logic [4:0]  d_lz;
    logic [1:0]  d_sum_top;
    logic        d_out_valid, d_out_ready, d_max_exp, d_min_exp, d_flush;
    logic [12:0] d_excess;
    logic        d_sticky_ovf, d_sticky_unf, d_flag_clr;

    exp_update_pipe #(.EXP_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_in(exp_in), .ovf(ovf), .ovf_rnd(ovf_rnd),
        .lz_shift(lz_shift), .one_shift_left(one_shift_left),
        .sum_top(sum_top), .ftz_mode(ftz_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .max_exp(max_exp), .min_exp(min_exp),
        .excess_shift(excess_shift), .flush_zero(flush_zero),
        .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
        .flag_clr(flag_clr)
    );

    exp_update_pipe #(.EXP_W(11)) dut_dp (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .exp_in(d_exp_in), .ovf(d_ovf), .ovf_rnd(d_ovf_rnd),
        .lz_shift(d_lz), .one_shift_left(d_osl),
        .sum_top(d_sum_top), .ftz_mode(d_ftz),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .exp_out(d_exp_out), .max_exp(d_max_exp), .min_exp(d_min_exp),
        .excess_shift(d_excess), .flush_zero(d_flush),
        .sticky_ovf(d_sticky_ovf), .sticky_unf(d_sticky_unf),
        .flag_clr(d_flag_clr)
    );

    typedef struct {
        int       e;
        bit       ov;
        bit       rn;
        int       lz;
        bit       osl;
        bit [1:0] st;
        bit       ftz;
    } op_t;

    typedef struct {
        int eo;
        bit mx;
        bit mn;
        int xs;
        bit fz;
    } res_t;

    typedef struct {
        op_t  op;
        res_t r;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit sk_ovf = 0;
    bit sk_unf = 0;

    vec_t tbl[13];
    res_t q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference: exponent arithmetic on plain integers, then IEEE range rules
    function automatic res_t model(input op_t o, input int w);
        res_t r;
        int sh, ie, top;
        r  = '{default: 0};
        sh = (o.ov == 1'b0 && o.st == 2'b00) ? o.lz : int'(o.osl);
        ie = o.e + int'(o.ov) + int'(o.rn) - sh;
        top = (1 << w) - 1;
        if (ie >= top) begin
            r.eo = top;
            r.mx = 1;
        end else if (ie <= 0) begin
            r.mn = 1;
            if (o.ftz) r.fz = 1;
            else       r.xs = -ie;
        end else begin
            r.eo = ie;
        end
        return r;
    endfunction

    task automatic drive(input op_t o);
        exp_in         = o.e[7:0];
        ovf            = o.ov;
        ovf_rnd        = o.rn;
        lz_shift       = o.lz[4:0];
        one_shift_left = o.osl;
        sum_top        = o.st;
        ftz_mode       = o.ftz;
    endtask

    task automatic check_res(input string tag, input res_t r);
        chk({tag, "_exp_out"}, exp_out, r.eo);
        chk({tag, "_max_exp"}, max_exp, r.mx);
        chk({tag, "_min_exp"}, min_exp, r.mn);
        chk({tag, "_excess"}, excess_shift, r.xs);
        chk({tag, "_flush"}, flush_zero, r.fz);
    endtask

    task automatic run_op(input op_t o, input res_t r, input bit clr,
                          input string tag);
        int n;
        drive(o);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flag_clr  = 1'b0;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        check_res(tag, r);
        flag_clr = clr;
        sk_ovf = (sk_ovf & ~clr) | r.mx;
        sk_unf = (sk_unf & ~clr) | r.mn;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk({tag, "_sticky_ovf"}, sticky_ovf, sk_ovf);
        chk({tag, "_sticky_unf"}, sticky_unf, sk_unf);
    endtask

    op_t  o;
    res_t r;
    op_t  bp[4];
    res_t bpr[4];
    op_t  dp[3];
    res_t dr;

    initial begin
        rst = 1'b1;
        in_valid = 0; out_ready = 0; flag_clr = 0;
        exp_in = 0; ovf = 0; ovf_rnd = 0; lz_shift = 0;
        one_shift_left = 0; sum_top = 0; ftz_mode = 0;
        d_in_valid = 0; d_out_ready = 0; d_flag_clr = 0;
        d_exp_in = 0; d_ovf = 0; d_ovf_rnd = 0; d_lz = 0;
        d_osl = 0; d_sum_top = 0; d_ftz = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_exp_out", exp_out, 0);
        chk("rst_max_min", {max_exp, min_exp, flush_zero}, 0);
        chk("rst_excess", excess_shift, 0);
        chk("rst_sticky", {sticky_ovf, sticky_unf}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dp_out_valid", d_out_valid, 0);

        tbl[0]  = '{'{100, 0, 0, 3, 0, 2'b00, 0}, '{97, 0, 0, 0, 0}};
        tbl[1]  = '{'{254, 1, 0, 0, 0, 2'b10, 0}, '{255, 1, 0, 0, 0}};
        tbl[2]  = '{'{2, 0, 0, 5, 0, 2'b00, 0}, '{0, 0, 1, 3, 0}};
        tbl[3]  = '{'{2, 0, 0, 5, 0, 2'b00, 1}, '{0, 0, 1, 0, 1}};
        tbl[4]  = '{'{5, 0, 0, 5, 0, 2'b00, 0}, '{0, 0, 1, 0, 0}};
        tbl[5]  = '{'{50, 0, 0, 9, 1, 2'b01, 0}, '{49, 0, 0, 0, 0}};
        tbl[6]  = '{'{254, 0, 0, 7, 0, 2'b01, 0}, '{254, 0, 0, 0, 0}};
        tbl[7]  = '{'{253, 1, 1, 0, 0, 2'b10, 0}, '{255, 1, 0, 0, 0}};
        tbl[8]  = '{'{0, 0, 0, 31, 0, 2'b00, 0}, '{0, 0, 1, 31, 0}};
        tbl[9]  = '{'{1, 0, 0, 0, 1, 2'b01, 0}, '{0, 0, 1, 0, 0}};
        tbl[10] = '{'{255, 1, 1, 0, 0, 2'b11, 1}, '{255, 1, 0, 0, 0}};
        tbl[11] = '{'{10, 1, 0, 7, 0, 2'b00, 0}, '{11, 0, 0, 0, 0}};
        tbl[12] = '{'{40, 0, 1, 4, 0, 2'b00, 0}, '{37, 0, 0, 0, 0}};

        @(posedge clk); #1;
        for (int i = 0; i < 13; i++)
            run_op(tbl[i].op, tbl[i].r, 1'b0, $sformatf("v%0d", i));

        // flag_clr alone, then flag_clr colliding with an overflow result
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        sk_ovf = 0;
        sk_unf = 0;
        chk("clr_sticky_ovf", sticky_ovf, 0);
        chk("clr_sticky_unf", sticky_unf, 0);
        run_op(tbl[1].op, tbl[1].r, 1'b1, "clr_vs_set");

        // backpressure: 4 ops, downstream stalled for the first cycles
        for (int i = 0; i < 4; i++) begin
            bp[i]  = '{10 * (i + 1), 0, 0, 0, 0, 2'b01, 0};
            bpr[i] = model(bp[i], 8);
        end
        begin
            int k, got;
            logic [7:0] saved;
            k = 0;
            got = 0;
            saved = '0;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                out_ready = (cyc >= 4);
                in_valid  = (k < 4);
                if (k < 4) drive(bp[k]);
                if (cyc == 2) begin
                    chk("bp_in_ready_drop", in_ready, 0);
                    chk("bp_accepted", k, 2);
                    chk("bp_out_valid", out_valid, 1);
                    saved = exp_out;
                end
                if (cyc == 3) begin
                    chk("bp_hold_exp", exp_out, saved);
                    chk("bp_hold_valid", out_valid, 1);
                end
                #4;
                if (out_valid && out_ready) begin
                    check_res($sformatf("bp%0d", got), bpr[got]);
                    got++;
                end
                if (in_valid && in_ready) k++;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            chk("bp_all_out", got, 4);
            chk("bp_no_dup", out_valid, 0);
        end

        // randomized traffic against the queue-based reference
        for (int c = 0; c < 400; c++) begin
            bit hs;
            res_t e;
            o.e   = $urandom_range(0, 255);
            o.ov  = ($urandom_range(0, 3) == 0);
            o.rn  = ($urandom_range(0, 3) == 0);
            o.lz  = $urandom_range(0, 31);
            o.osl = $urandom_range(0, 1);
            o.st  = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(0, 3));
            o.ftz = $urandom_range(0, 1);
            drive(o);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flag_clr  = ($urandom_range(0, 15) == 0);
            #4;
            hs = out_valid && out_ready;
            e  = '{default: 0};
            if (hs) begin
                chk("rnd_expected_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check_res("rnd", e);
                end
            end
            sk_ovf = (sk_ovf & ~flag_clr) | (hs & e.mx);
            sk_unf = (sk_unf & ~flag_clr) | (hs & e.mn);
            if (in_valid && in_ready) q.push_back(model(o, 8));
            @(posedge clk); #1;
            chk("rnd_sticky_ovf", sticky_ovf, sk_ovf);
            chk("rnd_sticky_unf", sticky_unf, sk_unf);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flag_clr  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #4;
            if (out_valid && q.size() != 0) begin
                r = q.pop_front();
                check_res("drain", r);
            end
            @(posedge clk); #1;
        end
        chk("rnd_drained", q.size(), 0);

        // EXP_W=11 instance
        dp[0] = '{2046, 1, 1, 0, 0, 2'b10, 0};
        dp[1] = '{1500, 0, 0, 4, 0, 2'b00, 0};
        dp[2] = '{3, 0, 0, 10, 0, 2'b00, 0};
        d_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dr = model(dp[i], 11);
            d_exp_in  = dp[i].e[10:0];
            d_ovf     = dp[i].ov;
            d_ovf_rnd = dp[i].rn;
            d_lz      = dp[i].lz[4:0];
            d_osl     = dp[i].osl;
            d_sum_top = dp[i].st;
            d_ftz     = dp[i].ftz;
            d_in_valid = 1'b1;
            @(posedge clk); #1;
            d_in_valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("dp%0d_valid", i), d_out_valid, 1);
            chk($sformatf("dp%0d_exp", i), d_exp_out, dr.eo);
            chk($sformatf("dp%0d_max", i), d_max_exp, dr.mx);
            chk($sformatf("dp%0d_min", i), d_min_exp, dr.mn);
            chk($sformatf("dp%0d_excess", i), d_excess, dr.xs);
            @(posedge clk); #1;
        end
        chk("dp_sticky_ovf", d_sticky_ovf, 1);
        chk("dp_sticky_unf", d_sticky_unf, 1);

        // reset with both stages full
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(tbl[1].op);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sticky", {sticky_ovf, sticky_unf}, 0);
        chk("mid_rst_exp_out", exp_out, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_rst_stale%0d", c), out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_update_pipe.md
Name: exp_update_pipe

Overview:
- Parametrised, pipelined successor to the FP adder's combinational exponent-update stage.
- Takes the pre-normalisation exponent, carry/rounding overflow bits, leading-zero shift count and top sum bits, then produces the normalised exponent, overflow/underflow classification, excess denormal shift and sticky IEEE status flags.
- Sits between the adder's normaliser/rounder and the result packer.
- Uses a 2-stage valid/ready pipeline so the FPU can stall downstream without losing operations.

Parameters:
- EXP_W, 8, exponent field width (8 single, 11 double).
- SUM_W, 27, adder sum width; only bits SUM_W-1 and SUM_W-2 are consumed.
- SHIFT_W, 5, width of the leading-zero shift count.
- EXC_W, EXP_W+2, width of the excess-shift output.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept the input this cycle.
- exp_in  in  EXP_W  selected (larger) biased exponent.
- ovf  in  1  adder carry-out (needs 1 right shift).
- ovf_rnd  in  1  rounding overflow (needs 1 right shift).
- lz_shift  in  SHIFT_W  massive left-shift count (leading zeros).
- one_shift_left  in  1  single left-shift request.
- sum_top  in  2  {sum[SUM_W-1], sum[SUM_W-2]}.
- ftz_mode  in  1  flush-to-zero mode, sampled with in_valid.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- exp_out  out  EXP_W  updated exponent.
- max_exp  out  1  result exponent saturated to all-ones.
- min_exp  out  1  result exponent is zero (subnormal or flushed).
- excess_shift  out  EXC_W  extra right shift the mantissa needs for a subnormal result.
- flush_zero  out  1  result must be forced to signed zero (FTZ underflow).
- sticky_ovf  out  1  accumulated overflow flag.
- sticky_unf  out  1  accumulated underflow flag.
- flag_clr  in  1  clear both sticky flags.

Behaviour:
- Reset: all outputs 0; both pipeline stages empty; in_ready=1 in the cycle after reset deasserts.
- Path select: if {ovf,sum_top}==3'b000, shift = lz_shift (left path); otherwise shift = one_shift_left.
- Stage 1 registers ie = exp_in + ovf + ovf_rnd - shift. ie is computed signed, EXP_W+2 bits wide, with all operands zero-extended. It also registers ftz_mode.
- Stage 2 classifies ie, checked in this order:
  - Overflow: ie >= 2^EXP_W - 1 and ie not negative. Drive exp_out all-ones, max_exp=1, excess_shift=0, and set overflow for this result.
  - Underflow: ie <= 0. Drive exp_out=0 and min_exp=1. If ftz_mode=0: excess_shift = -ie (truncated/zero-extended to EXC_W), flush_zero=0. If ftz_mode=1: excess_shift=0, flush_zero=1. Set underflow for this result. The case ie==0 gives excess_shift=0, min_exp=1 and underflow=1.
  - Otherwise: exp_out = ie[EXP_W-1:0]; all flags 0.
- Latency is 2 cycles from in_valid&&in_ready to out_valid. Throughput is 1 per cycle while out_ready=1.
- Handshake:
  - A stage advances when it is empty or when its successor advances.
  - in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready.
  - Outputs hold stable while out_valid && !out_ready.
  - in_ready is combinational from out_ready (no skid buffer).
- Sticky flags:
  - On an output handshake (out_valid && out_ready), OR the result's overflow/underflow into sticky_ovf/sticky_unf.
  - flag_clr clears both flags. If flag_clr and a setting handshake occur in the same cycle, set wins (the flag ends at 1).
  - Sticky flags are unaffected by stalls.
- Reset mid-operation: both in-flight operations are discarded, out_valid=0 next cycle, sticky flags cleared.
- Inputs are don't-care when in_valid=0, and no state changes in that case.

Decomposition:
- Shared package fpu_pkg holds:
  - localparams for single/double EXP_W (8/11) and EXP_BIAS.
  - typedef exp_class_t {EXP_NORMAL, EXP_MAX, EXP_MIN}.
  - function exp_all_ones(EXP_W).
- One natural sub-module, exp_classify: purely combinational stage-2 logic taking ie and ftz and producing exp_out, max_exp, min_exp, excess_shift, flush_zero and the class. It is reusable by the multiplier's exponent path.

Test Plan:
- Normal, left path, EXP_W=8: exp_in=100, ovf=0, sum_top=00, lz_shift=3 -> exp_out=97, flags 0, out_valid 2 cycles after accept.
- Carry path: exp_in=254, ovf=1, ovf_rnd=0, sum_top=10 -> ie=255 -> exp_out=8'hFF, max_exp=1, sticky_ovf=1 after handshake.
- Subnormal: exp_in=2, sum_top=00, lz_shift=5, ftz_mode=0 -> exp_out=0, min_exp=1, excess_shift=3. Repeat with ftz_mode=1 -> excess_shift=0, flush_zero=1. sticky_unf=1 in both cases.
- Backpressure:
  - Stream 4 ops with out_ready=0 for 3 cycles. Required: in_ready drops after 2 ops are accepted; outputs hold stable; all 4 results emerge in order with none lost or duplicated.
  - flag_clr asserted in the same cycle as an overflow handshake -> sticky_ovf=1.
- EXP_W=11 instance: exp_in=2046, ovf=1, ovf_rnd=1 -> exp_out=11'h7FF, max_exp=1.
- Assert rst while both stages are full -> next cycle out_valid=0, sticky flags 0, and no stale result appears afterwards.
